// File: rtl/ingame_text_renderer_if.sv
// Text ROM and font ROM bus between the renderer and its two lookup ROMs.
// The renderer drives both addresses; the ROM side returns ASCII and glyph rows.
interface ingame_text_renderer_if;
  logic [3:0]  text_addr;
  logic [6:0]  text_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;

  modport master (
    output text_addr,
    output font_addr,
    input  text_data,
    input  font_data
  );

  modport slave (
    input  text_addr,
    input  font_addr,
    output text_data,
    output font_data
  );
endinterface

// File: rtl/ingame_text_renderer.sv
// Pixel-stream renderer for the status line "score:NNN team:T".
// A three-stage pixel pipeline turns DrawX/DrawY into pixel_on three cycles later,
// while a once-per-frame double-dabble engine refreshes the displayed score digits.
module ingame_text_renderer #(
  parameter int TEXT_X0 = 16,
  parameter int TEXT_Y0 = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          frame_start,
  input  logic [9:0]                    DrawX,
  input  logic [9:0]                    DrawY,
  input  logic [9:0]                    score,
  input  logic [3:0]                    team,
  ingame_text_renderer_if.master        rom,
  output logic                          pixel_on,
  output logic                          conv_busy
);

  localparam logic [10:0] X_LO = 11'(TEXT_X0);
  localparam logic [10:0] X_HI = 11'(TEXT_X0 + 127);
  localparam logic [10:0] Y_LO = 11'(TEXT_Y0);
  localparam logic [10:0] Y_HI = 11'(TEXT_Y0 + 15);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    LOAD    = 2'd2
  } bcdState_t;

  bcdState_t   state;
  bcdState_t   stateNext;

  logic [9:0]  shadowBin;
  logic [3:0]  shadowTeam;
  logic [11:0] bcdAcc;
  logic [11:0] bcdAdj;
  logic [3:0]  iterCount;

  logic [3:0]  dispHund;
  logic [3:0]  dispTens;
  logic [3:0]  dispOnes;
  logic [3:0]  dispTeam;
  logic [6:0]  teamChar;

  logic        inRegionNow;
  logic [6:0]  dxLow;
  logic [3:0]  dyLow;

  logic        s1InRegion;
  logic [3:0]  s1Slot;
  logic [3:0]  s1Row;
  logic [2:0]  s1Col;

  logic [3:0]  textAddr;
  logic [6:0]  charCode;

  logic        s2InRegion;
  logic [2:0]  s2Col;
  logic        s2Blank;

  function automatic logic [3:0] dabble(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  endfunction

  // Zero-extend the beam position by one bit so the region compare cannot wrap.
  assign inRegionNow = ({1'b0, DrawX} >= X_LO) && ({1'b0, DrawX} <= X_HI) &&
                       ({1'b0, DrawY} >= Y_LO) && ({1'b0, DrawY} <= Y_HI);
  assign dxLow = 7'(DrawX - 10'(TEXT_X0));
  assign dyLow = 4'(DrawY - 10'(TEXT_Y0));

  // Stage 1: latch region flag and the slot/row/column coordinates of this pixel.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1InRegion <= 1'b0;
      s1Slot     <= 4'd0;
      s1Row      <= 4'd0;
      s1Col      <= 3'd0;
    end else begin
      s1InRegion <= inRegionNow;
      s1Slot     <= dxLow[6:3];
      s1Row      <= dyLow;
      s1Col      <= dxLow[2:0];
    end
  end

  assign teamChar = (dispTeam <= 4'd9) ? 7'h30 + {3'b000, dispTeam} : 7'h3F;

  // Map the stage-1 slot to a text ROM address and pick the character code for it.
  always_comb begin
    textAddr = 4'd11;
    charCode = 7'h00;
    if (s1InRegion) begin
      case (s1Slot)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
          textAddr = s1Slot;
          charCode = rom.text_data;
        end
        4'd6:    charCode = 7'h30 + {3'b000, dispHund};
        4'd7:    charCode = 7'h30 + {3'b000, dispTens};
        4'd8:    charCode = 7'h30 + {3'b000, dispOnes};
        4'd9: begin
          textAddr = 4'd11;
          charCode = rom.text_data;
        end
        4'd10, 4'd11, 4'd12, 4'd13, 4'd14: begin
          textAddr = s1Slot - 4'd4;
          charCode = rom.text_data;
        end
        default: charCode = teamChar;
      endcase
    end
  end

  assign rom.text_addr = textAddr;
  assign rom.font_addr = s1InRegion ? {charCode, s1Row} : 11'd0;

  // Stage 2: carry the column and blank flag alongside the font ROM read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s2InRegion <= 1'b0;
      s2Col      <= 3'd0;
      s2Blank    <= 1'b0;
    end else begin
      s2InRegion <= s1InRegion;
      s2Col      <= s1Col;
      s2Blank    <= (charCode == 7'h00);
    end
  end

  // Output stage: select the glyph bit for this column, leftmost pixel in bit 7.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pixel_on <= 1'b0;
    end else begin
      pixel_on <= s2InRegion & ~s2Blank & rom.font_data[3'd7 - s2Col];
    end
  end

  // BCD engine state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // BCD engine next state: one capture, ten shift iterations, one load.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (frame_start) stateNext = CONVERT;
      CONVERT: if (iterCount == 4'd9) stateNext = LOAD;
      LOAD:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign conv_busy = (state != IDLE);
  assign bcdAdj = {dabble(bcdAcc[11:8]), dabble(bcdAcc[7:4]), dabble(bcdAcc[3:0])};

  // BCD datapath: shadow the inputs, run add-3/shift, publish digits only on LOAD.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadowBin  <= 10'd0;
      shadowTeam <= 4'd0;
      bcdAcc     <= 12'd0;
      iterCount  <= 4'd0;
      dispHund   <= 4'd0;
      dispTens   <= 4'd0;
      dispOnes   <= 4'd0;
      dispTeam   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            shadowBin  <= (score > 10'd999) ? 10'd999 : score;
            shadowTeam <= team;
            bcdAcc     <= 12'd0;
            iterCount  <= 4'd0;
          end
        end
        CONVERT: begin
          bcdAcc    <= 12'({bcdAdj, shadowBin[9]});
          shadowBin <= {shadowBin[8:0], 1'b0};
          iterCount <= iterCount + 4'd1;
        end
        LOAD: begin
          dispHund <= bcdAcc[11:8];
          dispTens <= bcdAcc[7:4];
          dispOnes <= bcdAcc[3:0];
          dispTeam <= shadowTeam;
        end
        default: begin
          iterCount <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ingame_text_renderer.sv
// Bench for ingame_text_renderer: text ROM and synchronous font ROM models,
// a string-level model of the status line, and one task per scenario.
module tb_ingame_text_renderer;

  localparam int X0 = 16;
  localparam int Y0 = 8;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_start = 1'b0;
  logic [9:0] DrawX = 10'd0;
  logic [9:0] DrawY = 10'd0;
  logic [9:0] score = 10'd0;
  logic [3:0] team = 4'd0;
  logic       pixel_on;
  logic       conv_busy;

  int  checkCount = 0;
  int  passCount  = 0;
  int  modelScore = 0;
  int  modelTeam  = 0;
  bit  fontAll80  = 1'b0;
  logic [6:0] textRom [0:15];

  ingame_text_renderer_if romIf ();

  ingame_text_renderer #(.TEXT_X0(X0), .TEXT_Y0(Y0)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .score       (score),
    .team        (team),
    .rom         (romIf.master),
    .pixel_on    (pixel_on),
    .conv_busy   (conv_busy)
  );

  // Pixel clock.
  always #5 Clk = ~Clk;

  // Arbitrary but deterministic glyph pattern, or a single left pixel when requested.
  function automatic logic [7:0] fontFn(input logic [10:0] addr);
    if (fontAll80) return 8'h80;
    return 8'((int'(addr) * 167) ^ (int'(addr) >> 3) ^ 8'h5A);
  endfunction

  // Combinational text ROM.
  assign romIf.text_data = textRom[romIf.text_addr];

  // Synchronous font ROM, one cycle of read latency.
  always @(posedge Clk) romIf.font_data <= fontFn(romIf.font_addr);

  function automatic bit inRegionM(input int x, input int y);
    return (x >= X0) && (x <= X0 + 127) && (y >= Y0) && (y <= Y0 + 15);
  endfunction

  function automatic logic [6:0] modelChar(input int slot);
    string lblScore;
    string lblTeam;
    int s;
    lblScore = "score:";
    lblTeam  = "team:";
    s = (modelScore > 999) ? 999 : modelScore;
    if (slot < 6)  return 7'(lblScore[slot]);
    if (slot == 6) return 7'(48 + s / 100);
    if (slot == 7) return 7'(48 + (s / 10) % 10);
    if (slot == 8) return 7'(48 + s % 10);
    if (slot == 9) return 7'h00;
    if (slot < 15) return 7'(lblTeam[slot - 10]);
    return (modelTeam <= 9) ? 7'(48 + modelTeam) : 7'h3F;
  endfunction

  function automatic logic [3:0] expTextAddr(input int x, input int y);
    int slot;
    if (!inRegionM(x, y)) return 4'd11;
    slot = (x - X0) / 8;
    if (slot < 6) return 4'(slot);
    if (slot >= 10 && slot <= 14) return 4'(slot - 4);
    return 4'd11;
  endfunction

  function automatic logic [10:0] expFontAddr(input int x, input int y);
    if (!inRegionM(x, y)) return 11'd0;
    return {modelChar((x - X0) / 8), 4'(y - Y0)};
  endfunction

  function automatic bit expPixel(input int x, input int y);
    logic [6:0] ch;
    logic [7:0] g;
    int col;
    if (!inRegionM(x, y)) return 1'b0;
    ch = modelChar((x - X0) / 8);
    if (ch == 7'h00) return 1'b0;
    g = fontFn({ch, 4'(y - Y0)});
    col = (x - X0) % 8;
    return g[7 - col];
  endfunction

  task automatic applyStimulus(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    frame_start = 1'b0;
    repeat (3) applyStimulus(X0 + 3, Y0 + 2);
    checkCount++;
    if (pixel_on !== 1'b0) $display("[TB] FAIL reset_pixel_on: got %0b expected 0", pixel_on);
    else passCount++;
    checkCount++;
    if (conv_busy !== 1'b0) $display("[TB] FAIL reset_conv_busy: got %0b expected 0", conv_busy);
    else passCount++;
    checkCount++;
    if (romIf.text_addr !== 4'd11) $display("[TB] FAIL reset_text_addr: got %0d expected 11", romIf.text_addr);
    else passCount++;
    checkCount++;
    if (romIf.font_addr !== 11'd0) $display("[TB] FAIL reset_font_addr: got %0h expected 0", romIf.font_addr);
    else passCount++;
    Reset = 1'b0;
    modelScore = 0;
    modelTeam = 0;
    applyStimulus(0, 0);
    checkCount++;
    if (conv_busy !== 1'b0) $display("[TB] FAIL reset_release_busy: got %0b expected 0", conv_busy);
    else passCount++;
  endtask

  task automatic test_row_scan();
    int px[$];
    int y;
    int x;
    y = Y0 + 8;
    for (int i = 0; i < 162; i++) begin
      x = (i < 160) ? i : 0;
      px.push_back(x);
      applyStimulus(x, y);
      checkCount++;
      if (romIf.text_addr !== expTextAddr(x, y))
        $display("[TB] FAIL scan_text_addr x=%0d: got %0d expected %0d", x, romIf.text_addr, expTextAddr(x, y));
      else passCount++;
      checkCount++;
      if (romIf.font_addr !== expFontAddr(x, y))
        $display("[TB] FAIL scan_font_addr x=%0d: got %0h expected %0h", x, romIf.font_addr, expFontAddr(x, y));
      else passCount++;
      if (i >= 2) begin
        checkCount++;
        if (pixel_on !== expPixel(px[i - 2], y))
          $display("[TB] FAIL scan_pixel x=%0d: got %0b expected %0b", px[i - 2], pixel_on, expPixel(px[i - 2], y));
        else passCount++;
      end
    end
  endtask

  task automatic test_random_stream(input int count);
    int px[$];
    int py[$];
    int x;
    int y;
    for (int i = 0; i < count + 2; i++) begin
      if (i == 0)      begin x = X0 - 1;   y = Y0;      end
      else if (i == 1) begin x = X0 + 128; y = Y0 + 3;  end
      else if (i == 2) begin x = X0 + 5;   y = Y0 + 16; end
      else if (i == 3) begin x = X0 + 9;   y = Y0 - 1;  end
      else if (i < count) begin
        x = $urandom_range(X0 + 131, X0 - 4);
        y = $urandom_range(Y0 + 17, Y0 - 2);
      end else begin
        x = 0; y = 0;
      end
      px.push_back(x);
      py.push_back(y);
      applyStimulus(x, y);
      checkCount++;
      if (romIf.font_addr !== expFontAddr(x, y))
        $display("[TB] FAIL stream_font_addr (%0d,%0d): got %0h expected %0h", x, y, romIf.font_addr, expFontAddr(x, y));
      else passCount++;
      if (i >= 2) begin
        checkCount++;
        if (pixel_on !== expPixel(px[i - 2], py[i - 2]))
          $display("[TB] FAIL stream_pixel (%0d,%0d): got %0b expected %0b", px[i - 2], py[i - 2], pixel_on, expPixel(px[i - 2], py[i - 2]));
        else passCount++;
      end
    end
  endtask

  task automatic test_conversion(input int sc, input int tm);
    int n;
    int slots[4];
    int row;
    slots = '{6, 7, 8, 15};
    score = 10'(sc);
    team = 4'(tm);
    frame_start = 1'b1;
    applyStimulus(0, 0);
    frame_start = 1'b0;
    n = 0;
    while (conv_busy && n < 40) begin
      n++;
      applyStimulus(0, 0);
    end
    checkCount++;
    if (n !== 11) $display("[TB] FAIL conv_busy_cycles score=%0d: got %0d expected 11", sc, n);
    else passCount++;
    modelScore = sc;
    modelTeam = tm;
    foreach (slots[k]) begin
      row = $urandom_range(15, 0);
      applyStimulus(X0 + 8 * slots[k] + $urandom_range(7, 0), Y0 + row);
      checkCount++;
      if (romIf.font_addr !== {modelChar(slots[k]), 4'(row)})
        $display("[TB] FAIL digit_font_addr score=%0d slot=%0d: got %0h expected %0h", sc, slots[k], romIf.font_addr, {modelChar(slots[k]), 4'(row)});
      else passCount++;
    end
  endtask

  task automatic test_latency();
    int row;
    bit lit;
    fontAll80 = 1'b1;
    repeat (3) applyStimulus(0, 0);
    for (int k = 0; k < 16; k++) begin
      row = $urandom_range(15, 0);
      lit = (modelChar(k) != 7'h00);
      applyStimulus(X0 + 8 * k, Y0 + row);
      for (int e = 2; e <= 5; e++) begin
        applyStimulus(0, 0);
        checkCount++;
        if (pixel_on !== ((e == 3) && lit))
          $display("[TB] FAIL latency slot=%0d edge=%0d: got %0b expected %0b", k, e, pixel_on, (e == 3) && lit);
        else passCount++;
      end
    end
    fontAll80 = 1'b0;
  endtask

  task automatic test_midframe_change();
    int n;
    int scoreA;
    int row;
    score = 10'((modelScore + 123) % 1000);
    team = 4'((modelTeam + 1) % 16);
    repeat (4) applyStimulus(0, 0);
    for (int k = 6; k <= 8; k++) begin
      row = $urandom_range(15, 0);
      applyStimulus(X0 + 8 * k, Y0 + row);
      checkCount++;
      if (romIf.font_addr !== {modelChar(k), 4'(row)})
        $display("[TB] FAIL midframe_hold slot=%0d: got %0h expected %0h", k, romIf.font_addr, {modelChar(k), 4'(row)});
      else passCount++;
    end
    scoreA = $urandom_range(999, 100);
    score = 10'(scoreA);
    team = 4'd4;
    frame_start = 1'b1;
    applyStimulus(0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (conv_busy) n++;
      if (i == 3) begin
        score = 10'(999 - scoreA);
        team = 4'd8;
        frame_start = 1'b1;
      end else begin
        frame_start = 1'b0;
      end
      applyStimulus(0, 0);
    end
    checkCount++;
    if (n !== 11) $display("[TB] FAIL busy_with_ignored_pulse: got %0d expected 11", n);
    else passCount++;
    modelScore = scoreA;
    modelTeam = 4;
    for (int k = 6; k <= 9; k++) begin
      row = $urandom_range(15, 0);
      applyStimulus(X0 + 8 * (k == 9 ? 15 : k), Y0 + row);
      checkCount++;
      if (romIf.font_addr !== {modelChar(k == 9 ? 15 : k), 4'(row)})
        $display("[TB] FAIL ignored_pulse_digit slot=%0d: got %0h expected %0h", k, romIf.font_addr, {modelChar(k == 9 ? 15 : k), 4'(row)});
      else passCount++;
    end
  endtask

  task automatic test_reset_mid_conversion();
    int row;
    score = 10'd555;
    team = 4'd7;
    frame_start = 1'b1;
    applyStimulus(0, 0);
    frame_start = 1'b0;
    repeat (4) applyStimulus(X0 + 50, Y0 + 4);
    Reset = 1'b1;
    applyStimulus(X0 + 8 * 6, Y0 + 3);
    checkCount++;
    if (conv_busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %0b expected 0", conv_busy);
    else passCount++;
    checkCount++;
    if (pixel_on !== 1'b0) $display("[TB] FAIL midreset_pixel: got %0b expected 0", pixel_on);
    else passCount++;
    checkCount++;
    if (romIf.font_addr !== 11'd0) $display("[TB] FAIL midreset_font_addr: got %0h expected 0", romIf.font_addr);
    else passCount++;
    Reset = 1'b0;
    modelScore = 0;
    modelTeam = 0;
    for (int k = 6; k <= 9; k++) begin
      row = $urandom_range(15, 0);
      applyStimulus(X0 + 8 * (k == 9 ? 15 : k), Y0 + row);
      checkCount++;
      if (romIf.font_addr !== {modelChar(k == 9 ? 15 : k), 4'(row)})
        $display("[TB] FAIL midreset_digit slot=%0d: got %0h expected %0h", k, romIf.font_addr, {modelChar(k == 9 ? 15 : k), 4'(row)});
      else passCount++;
    end
    Reset = 1'b1;
    frame_start = 1'b1;
    applyStimulus(0, 0);
    Reset = 1'b0;
    frame_start = 1'b0;
    applyStimulus(0, 0);
    checkCount++;
    if (conv_busy !== 1'b0) $display("[TB] FAIL reset_with_pulse_busy: got %0b expected 0", conv_busy);
    else passCount++;
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    string romText;
    romText = "score:team:";
    for (int i = 0; i < 16; i++) textRom[i] = (i < 11) ? 7'(romText[i]) : 7'h00;
    romIf.font_data = 8'h00;
    test_reset();
    test_row_scan();
    test_conversion(427, 3);
    test_conversion(1000, 12);
    test_conversion(1023, 9);
    test_conversion(0, 10);
    test_random_stream(120);
    for (int r = 0; r < 3; r++) begin
      test_conversion($urandom_range(1023, 0), $urandom_range(15, 0));
      test_random_stream(150);
    end
    test_row_scan();
    test_latency();
    test_midframe_change();
    test_reset_mid_conversion();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
